perf_counter_ctrl: RTL

- Machine-mode performance-counter bank controller.
- Owns mcycle, minstret and NB_CNT-3 programmable hpm counters, each PERF_CNT_LEN bits wide.
- Owns the per-counter event selects and mcountinhibit.
- Serves a single-cycle-issue CSR request port from the CSR unit.
- Sits beside the CSR file; takes raw event strobes from the pipeline (retire, stalls, branch mispredicts, cache misses).

---
 rtl/core_config_pkg.sv | 17 +
 rtl/perf_counter_slice.sv | 56 +++++
 rtl/perf_counter_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration: datapath widths, perf-counter defaults and CSR addresses.
package core_config_pkg;

  localparam int XLEN           = 32;
  localparam int PERF_CNT_LEN   = 64;
  localparam int PERF_NB_CNT    = 8;
  localparam int PERF_NB_EVENTS = 8;

  localparam logic [11:0] CSR_MCYCLE         = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH        = 12'hB80;
  localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT_BASE = 12'h320;
  localparam logic [11:0] CSR_PERF_OVF       = 12'h7C0;

  typedef logic [$clog2(PERF_NB_EVENTS+1)-1:0] perf_evt_sel_t;

endpackage

// File: rtl/perf_counter_slice.sv
// One performance counter: split low/high CSR loads, +1 increment, wrap strobe.
module perf_counter_slice
  import core_config_pkg::*;
#(
  parameter int W = PERF_CNT_LEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  logic            inc,
  input  logic            ld_lo,
  input  logic            ld_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [W-1:0]    cnt,
  output logic            wrap
);

  localparam int LO_W = (W > XLEN) ? XLEN : W;

  logic         load;
  logic [W-1:0] load_val;

  generate
    if (W > XLEN) begin : g_split
      // NOTE: defaults first so every path assigns load/load_val; no latch is inferred.
      always_comb begin
        load     = ld_lo | ld_hi;
        load_val = cnt;
        if (ld_lo) load_val[LO_W-1:0] = wdata[LO_W-1:0];
        if (ld_hi) load_val[W-1:LO_W] = wdata[W-LO_W-1:0];
      end
    end else begin : g_single
      logic unused_ld_hi;
      assign unused_ld_hi = ld_hi;
      always_comb begin
        load     = ld_lo;
        load_val = cnt;
        if (ld_lo) load_val = wdata[W-1:0];
      end
    end
  endgenerate

  // Only an increment from all-ones counts as a wrap; a write never does.
  assign wrap = clk_en & inc & ~load & (&cnt);

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clk_en) begin
      if (load)     cnt <= load_val;
      else if (inc) cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// Machine-mode perf-counter bank: mcycle, minstret, hpm counters, selects, inhibit.
// Optional sticky overflow vector and interrupt when PERF_OVF_IRQ_EN is defined.
module perf_counter_ctrl
  import core_config_pkg::*;
#(
  parameter int NB_CNT    = PERF_NB_CNT,
  parameter int NB_EVENTS = PERF_NB_EVENTS,
  parameter int EVT_W     = $clog2(NB_EVENTS+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NB_EVENTS-1:0] events,
  input  logic                 csr_req,
  input  logic                 csr_we,
  input  logic [11:0]          csr_addr,
  input  logic [XLEN-1:0]      csr_wdata,
  output logic                 csr_ack,
  output logic [XLEN-1:0]      csr_rdata,
  output logic                 csr_err,
  output logic                 ovf_irq
);

  logic                    accept, wr;
  logic [4:0]              idx;
  logic                    idx_ok, hit_lo, hit_hi, hit_cfg, hit_inh, hit_evt, hit_ovf;
  logic [NB_CNT-1:0]       inhibit;
  logic [EVT_W-1:0]        evt_sel [NB_CNT];
  logic [PERF_CNT_LEN-1:0] cnt     [NB_CNT];
  logic [NB_CNT-1:0]       inc, wrap, ld_lo, ld_hi;
  logic [PERF_CNT_LEN-1:0] rd_cnt;
  logic [EVT_W-1:0]        rd_sel;
  logic [XLEN-1:0]         rd_val;
  logic                    rd_err;

  assign accept  = csr_req & clk_en;
  assign wr      = accept & csr_we;
  assign idx     = csr_addr[4:0];
  assign idx_ok  = (int'(idx) < NB_CNT) && (idx != 5'd1);
  assign hit_lo  = (csr_addr[11:5] == CSR_MCYCLE[11:5]) && idx_ok;
  assign hit_hi  = (csr_addr[11:5] == CSR_MCYCLEH[11:5]) && idx_ok;
  assign hit_cfg = (csr_addr[11:5] == CSR_MHPMEVENT_BASE[11:5]);
  assign hit_inh = (csr_addr == CSR_MCOUNTINHIBIT);
  assign hit_evt = hit_cfg && idx_ok && (idx >= 5'd3);
`ifdef PERF_OVF_IRQ_EN
  assign hit_ovf = (csr_addr == CSR_PERF_OVF);
`else
  assign hit_ovf = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NB_CNT; i++) begin
      inc[i] = 1'b0;
      if (i == 0)      inc[i] = 1'b1;
      else if (i == 2) inc[i] = events[0];
      else if (i >= 3) begin
        // Selects of 0 or above NB_EVENTS match no event and never count.
        for (int e = 0; e < NB_EVENTS; e++)
          if (evt_sel[i] == EVT_W'(e + 1)) inc[i] = events[e];
      end
      inc[i]   = inc[i] & ~inhibit[i];
      ld_lo[i] = wr & hit_lo & (idx == 5'(i));
      ld_hi[i] = wr & hit_hi & (idx == 5'(i));
    end
  end

  for (genvar g = 0; g < NB_CNT; g++) begin : g_cnt
    if (g == 1) begin : g_rsvd
      assign cnt[g]  = '0;
      assign wrap[g] = 1'b0;
    end else begin : g_slice
      perf_counter_slice #(.W(PERF_CNT_LEN)) u_slice (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .inc    (inc[g]),
        .ld_lo  (ld_lo[g]),
        .ld_hi  (ld_hi[g]),
        .wdata  (csr_wdata),
        .cnt    (cnt[g]),
        .wrap   (wrap[g])
      );
    end
  end

`ifdef PERF_OVF_IRQ_EN
  logic [NB_CNT-1:0] ovf, ovf_nxt, ovf_clr;

  always_comb begin
    ovf_clr = (wr && hit_ovf) ? csr_wdata[NB_CNT-1:0] : '0;
    ovf_nxt = (ovf & ~ovf_clr) | (wrap & ~NB_CNT'(7));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf     <= '0;
      ovf_irq <= 1'b0;
    end else if (clk_en) begin
      ovf     <= ovf_nxt;
      ovf_irq <= |ovf_nxt;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = |wrap;
  assign ovf_irq     = 1'b0;
`endif

  always_comb begin
    rd_cnt = '0;
    rd_sel = '0;
    for (int i = 0; i < NB_CNT; i++) begin
      if (idx == 5'(i)) begin
        rd_cnt = cnt[i];
        rd_sel = evt_sel[i];
      end
    end
    rd_val = '0;
    rd_err = 1'b0;
    if (hit_lo)       rd_val = rd_cnt[XLEN-1:0];
    else if (hit_hi)  rd_val = XLEN'(rd_cnt >> XLEN);
    else if (hit_inh) rd_val = XLEN'(inhibit);
    else if (hit_evt) rd_val = XLEN'(rd_sel);
`ifdef PERF_OVF_IRQ_EN
    else if (hit_ovf) rd_val = XLEN'(ovf);
`endif
    else              rd_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inhibit   <= '0;
      csr_ack   <= 1'b0;
      csr_rdata <= '0;
      csr_err   <= 1'b0;
      // NOTE: evt_sel is a small flop array, so it is reset like any other register.
      for (int i = 0; i < NB_CNT; i++) evt_sel[i] <= '0;
    end else begin
      csr_ack <= accept;
      if (accept) begin
        csr_rdata <= rd_val;
        csr_err   <= rd_err;
      end
      if (wr && hit_inh) inhibit <= csr_wdata[NB_CNT-1:0] & ~NB_CNT'(2);
      for (int i = 3; i < NB_CNT; i++)
        if (wr && hit_evt && (idx == 5'(i))) evt_sel[i] <= csr_wdata[EVT_W-1:0];
    end
  end

endmodule
